execute_cc_cond: RTL and testbench
==================================

Name: execute_cc_cond

Overview:
- Consumer end of the execute-stage ALU datapath: takes ALU results (bitwise and arithmetic), holds the Y86 condition-code register (ZF, SF, OF), and evaluates jXX/cmovXX conditions.
- Contains the E-to-M pipeline register, with cmov destination squashing, stall and bubble.
- Sits between the ALU (and, xor, add, sub units) and the memory stage.

Parameters:
- WIDTH, 32, data path width of the ALU operands and result.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- e_valid  in  1  execute-stage slot holds a real instruction
- e_icode  in  4  instruction code (2 = rrmov/cmov, 6 = OPq, 7 = jXX)
- e_ifun  in  4  function code
- alu_a  in  WIDTH  ALU operand A (valA side)
- alu_b  in  WIDTH  ALU operand B (valB side)
- alu_result  in  WIDTH  ALU output, computed as b OP a
- e_valA  in  WIDTH  value passed through to memory stage
- e_dstE  in  4  destination register ID, 4'hF = none
- m_exc  in  1  memory stage holds an exception
- w_exc  in  1  writeback stage holds an exception
- m_stall  in  1  hold the M register
- m_bubble  in  1  inject a NOP into the M register
- cc_zf, cc_sf, cc_of  out  1 each  condition-code register
- e_cnd  out  1  combinational condition result from current CC and e_ifun
- M_valid  out  1  registered
- M_icode  out  4  registered
- M_cnd  out  1  registered
- M_valE  out  WIDTH  registered
- M_valA  out  WIDTH  registered
- M_dstE  out  4  registered

Behaviour:
- Reset (synchronous, dominates all):
  - cc_zf=1, cc_sf=0, cc_of=0.
  - M_valid=0, M_icode=4'h1 (nop), M_cnd=0, M_valE=0, M_valA=0, M_dstE=4'hF.
- Flag computation (combinational, from alu_result), with msb = WIDTH-1:
  - ZF = (alu_result==0); SF = alu_result[msb].
  - OF for ifun 0 (add): a[msb]==b[msb] and r[msb]!=a[msb].
  - OF for ifun 1 (sub, b-a): a[msb]!=b[msb] and r[msb]!=b[msb].
  - OF for ifun 2 (and), ifun 3 (xor): 0.
- set_cc = e_valid & (e_icode==6) & !m_exc & !w_exc & !m_stall. The CC register loads the new flags on a clock edge only when set_cc=1; otherwise it holds.
- e_cnd (combinational) uses the CC register value before any update in the same cycle:
  - ifun 0 always: 1
  - ifun 1 le: (SF^OF)|ZF
  - ifun 2 l: SF^OF
  - ifun 3 e: ZF
  - ifun 4 ne: !ZF
  - ifun 5 ge: !(SF^OF)
  - ifun 6 g: !(SF^OF)&!ZF
  - ifun 7-15: 0
- M register update priority per edge: reset > m_stall (hold all) > m_bubble (load the reset/NOP values) > normal load.
  - If m_stall and m_bubble are both asserted, stall wins.
- Normal load:
  - M_valid=e_valid, M_icode=e_icode, M_cnd=e_cnd, M_valE=alu_result, M_valA=e_valA.
  - M_dstE = 4'hF when e_icode==2 and e_cnd==0; otherwise M_dstE = e_dstE.
- Latency:
  - Flags become visible on cc_* one cycle after the OPq is in E.
  - A dependent jXX/cmov in the very next E slot sees the updated flags.
- Exception mid-stream: while m_exc or w_exc is asserted, no OPq modifies CC. The M register still loads normally unless stalled or bubbled.
- Reset asserted mid-stream discards the pending E instruction. No CC update occurs in that cycle.

Optional Feature:
- Macro: EXEC_BRANCH_STATS_EN.
- When defined, two extra outputs are added: jxx_total[31:0] and jxx_taken[31:0].
  - Each counts jXX instructions (e_valid & e_icode==7) as they advance into M, i.e. not stalled and not bubbled.
  - jxx_taken increments only when e_cnd=1.
  - Both counters saturate at 32'hFFFFFFFF and clear on reset.
- When not defined, the ports and counters do not exist and behaviour is otherwise identical.

Test Plan:
- After reset, subq with a=5, b=5 (result 0):
  - next cycle ZF=1, SF=0, OF=0.
  - Then jXX ifun 3 gives e_cnd=1; ifun 4 gives e_cnd=0.
- addq with a=32'h7FFFFFFF, b=1 (result 32'h80000000):
  - next cycle ZF=0, SF=1, OF=1.
  - le gives e_cnd=0 and ge gives e_cnd=1.
- andq with a=32'hF0F0F0F0, b=32'h0F0F0F0F (result 0):
  - ZF=1, OF=0.
  - Then cmov ifun 4 (ne) with e_dstE=3 gives M_dstE=4'hF and M_cnd=0.
- OPq with m_exc=1 and result 32'hFFFFFFFF:
  - CC keeps its prior value.
  - M_valE=32'hFFFFFFFF is still loaded.
- m_stall=1 and m_bubble=1 together with a new OPq in E:
  - M register and CC are both held.
  - Next cycle with m_bubble=1 only: M_icode=1, M_dstE=4'hF, M_valid=0.
- With EXEC_BRANCH_STATS_EN defined, issue 3 jXX instructions, 2 of them taken:
  - jxx_total=3, jxx_taken=2.
  - After reset, both counters read 0.

Source files
------------

// File: rtl/execute_cc_cond.sv
// Execute-stage condition codes, jXX/cmov condition evaluation and the E-to-M pipeline register.
// CC and M update one edge after E; m_stall holds M and blocks CC, m_bubble loads a NOP. Optional EXEC_BRANCH_STATS_EN adds jXX counters.
module execute_cc_cond #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             e_valid,
  input  logic [3:0]       e_icode,
  input  logic [3:0]       e_ifun,
  input  logic [WIDTH-1:0] alu_a,
  input  logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_result,
  input  logic [WIDTH-1:0] e_valA,
  input  logic [3:0]       e_dstE,
  input  logic             m_exc,
  input  logic             w_exc,
  input  logic             m_stall,
  input  logic             m_bubble,
`ifdef EXEC_BRANCH_STATS_EN
  output logic [31:0]      jxx_total,
  output logic [31:0]      jxx_taken,
`endif
  output logic             cc_zf,
  output logic             cc_sf,
  output logic             cc_of,
  output logic             e_cnd,
  output logic             M_valid,
  output logic [3:0]       M_icode,
  output logic             M_cnd,
  output logic [WIDTH-1:0] M_valE,
  output logic [WIDTH-1:0] M_valA,
  output logic [3:0]       M_dstE
);

  localparam int MSB = WIDTH - 1;
  localparam logic [3:0] ICODE_NOP  = 4'h1;
  localparam logic [3:0] ICODE_CMOV = 4'h2;
  localparam logic [3:0] ICODE_OPQ  = 4'h6;
  localparam logic [3:0] ICODE_JXX  = 4'h7;
  localparam logic [3:0] REG_NONE   = 4'hF;

  logic zf_q, sf_q, of_q;
  logic zf_d, sf_d, of_d;
  logic new_zf, new_sf, new_of;
  logic set_cc;

  // Only the sign bits of the operands matter for overflow detection.
  logic unused_operand_bits;
  assign unused_operand_bits = ^{alu_a[MSB-1:0], alu_b[MSB-1:0]};

  always_comb begin
    new_zf = (alu_result == '0);
    new_sf = alu_result[MSB];
    new_of = 1'b0;
    case (e_ifun)
      4'h0:    new_of = (alu_a[MSB] == alu_b[MSB]) && (alu_result[MSB] != alu_a[MSB]);
      4'h1:    new_of = (alu_a[MSB] != alu_b[MSB]) && (alu_result[MSB] != alu_b[MSB]);
      default: new_of = 1'b0;
    endcase
  end

  assign set_cc = e_valid && (e_icode == ICODE_OPQ) && !m_exc && !w_exc && !m_stall;

  always_comb begin
    zf_d = zf_q;
    sf_d = sf_q;
    of_d = of_q;
    if (set_cc) begin
      zf_d = new_zf;
      sf_d = new_sf;
      of_d = new_of;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      zf_q <= 1'b1;
      sf_q <= 1'b0;
      of_q <= 1'b0;
    end else begin
      zf_q <= zf_d;
      sf_q <= sf_d;
      of_q <= of_d;
    end
  end

  assign cc_zf = zf_q;
  assign cc_sf = sf_q;
  assign cc_of = of_q;

  // Condition uses the registered CC, so an OPq in the same slot does not affect it.
  always_comb begin
    e_cnd = 1'b0;
    case (e_ifun)
      4'h0:    e_cnd = 1'b1;
      4'h1:    e_cnd = (sf_q ^ of_q) | zf_q;
      4'h2:    e_cnd = sf_q ^ of_q;
      4'h3:    e_cnd = zf_q;
      4'h4:    e_cnd = !zf_q;
      4'h5:    e_cnd = !(sf_q ^ of_q);
      4'h6:    e_cnd = !(sf_q ^ of_q) && !zf_q;
      default: e_cnd = 1'b0;
    endcase
  end

  logic             m_valid_q, m_valid_d;
  logic [3:0]       m_icode_q, m_icode_d;
  logic             m_cnd_q,   m_cnd_d;
  logic [WIDTH-1:0] m_vale_q,  m_vale_d;
  logic [WIDTH-1:0] m_vala_q,  m_vala_d;
  logic [3:0]       m_dste_q,  m_dste_d;

  always_comb begin
    m_valid_d = m_valid_q;
    m_icode_d = m_icode_q;
    m_cnd_d   = m_cnd_q;
    m_vale_d  = m_vale_q;
    m_vala_d  = m_vala_q;
    m_dste_d  = m_dste_q;
    if (!m_stall) begin
      if (m_bubble) begin
        m_valid_d = 1'b0;
        m_icode_d = ICODE_NOP;
        m_cnd_d   = 1'b0;
        m_vale_d  = '0;
        m_vala_d  = '0;
        m_dste_d  = REG_NONE;
      end else begin
        m_valid_d = e_valid;
        m_icode_d = e_icode;
        m_cnd_d   = e_cnd;
        m_vale_d  = alu_result;
        m_vala_d  = e_valA;
        // A not-taken cmov must not write its destination.
        m_dste_d  = ((e_icode == ICODE_CMOV) && !e_cnd) ? REG_NONE : e_dstE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      m_valid_q <= 1'b0;
      m_icode_q <= ICODE_NOP;
      m_cnd_q   <= 1'b0;
      m_vale_q  <= '0;
      m_vala_q  <= '0;
      m_dste_q  <= REG_NONE;
    end else begin
      m_valid_q <= m_valid_d;
      m_icode_q <= m_icode_d;
      m_cnd_q   <= m_cnd_d;
      m_vale_q  <= m_vale_d;
      m_vala_q  <= m_vala_d;
      m_dste_q  <= m_dste_d;
    end
  end

  assign M_valid = m_valid_q;
  assign M_icode = m_icode_q;
  assign M_cnd   = m_cnd_q;
  assign M_valE  = m_vale_q;
  assign M_valA  = m_vala_q;
  assign M_dstE  = m_dste_q;

`ifdef EXEC_BRANCH_STATS_EN
  logic [31:0] jxx_total_q, jxx_total_d;
  logic [31:0] jxx_taken_q, jxx_taken_d;
  logic        jxx_advance;

  assign jxx_advance = e_valid && (e_icode == ICODE_JXX) && !m_stall && !m_bubble;

  always_comb begin
    jxx_total_d = jxx_total_q;
    jxx_taken_d = jxx_taken_q;
    if (jxx_advance) begin
      if (jxx_total_q != 32'hFFFF_FFFF) jxx_total_d = jxx_total_q + 32'd1;
      if (e_cnd && (jxx_taken_q != 32'hFFFF_FFFF)) jxx_taken_d = jxx_taken_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      jxx_total_q <= '0;
      jxx_taken_q <= '0;
    end else begin
      jxx_total_q <= jxx_total_d;
      jxx_taken_q <= jxx_taken_d;
    end
  end

  assign jxx_total = jxx_total_q;
  assign jxx_taken = jxx_taken_q;
`endif

endmodule

// File: tb/tb_execute_cc_cond.sv
// Directed bench for execute_cc_cond: CC flags, condition evaluation, M register stall/bubble/squash.
module tb_execute_cc_cond;
  localparam int WIDTH = 32;

  logic             clk = 1'b0;
  logic             reset;
  logic             e_valid;
  logic [3:0]       e_icode, e_ifun;
  logic [WIDTH-1:0] alu_a, alu_b, alu_result, e_valA;
  logic [3:0]       e_dstE;
  logic             m_exc, w_exc, m_stall, m_bubble;
  logic             cc_zf, cc_sf, cc_of, e_cnd;
  logic             M_valid, M_cnd;
  logic [3:0]       M_icode, M_dstE;
  logic [WIDTH-1:0] M_valE, M_valA;
`ifdef EXEC_BRANCH_STATS_EN
  logic [31:0]      jxx_total, jxx_taken;
`endif

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  execute_cc_cond #(.WIDTH(WIDTH)) dut (
    .clk(clk), .reset(reset), .e_valid(e_valid), .e_icode(e_icode), .e_ifun(e_ifun),
    .alu_a(alu_a), .alu_b(alu_b), .alu_result(alu_result), .e_valA(e_valA), .e_dstE(e_dstE),
    .m_exc(m_exc), .w_exc(w_exc), .m_stall(m_stall), .m_bubble(m_bubble),
`ifdef EXEC_BRANCH_STATS_EN
    .jxx_total(jxx_total), .jxx_taken(jxx_taken),
`endif
    .cc_zf(cc_zf), .cc_sf(cc_sf), .cc_of(cc_of), .e_cnd(e_cnd),
    .M_valid(M_valid), .M_icode(M_icode), .M_cnd(M_cnd),
    .M_valE(M_valE), .M_valA(M_valA), .M_dstE(M_dstE)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_cc(input string tag, input logic zf, input logic sf, input logic of);
    check({tag, ".cc"}, {29'd0, cc_zf, cc_sf, cc_of}, {29'd0, zf, sf, of});
  endtask

  task automatic drive(input logic v, input logic [3:0] ic, input logic [3:0] fn,
                       input logic [31:0] a, input logic [31:0] b, input logic [31:0] r,
                       input logic [31:0] va, input logic [3:0] dst);
    e_valid = v; e_icode = ic; e_ifun = fn;
    alu_a = a; alu_b = b; alu_result = r; e_valA = va; e_dstE = dst;
    #1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; m_exc = 1'b0; w_exc = 1'b0; m_stall = 1'b0; m_bubble = 1'b0;
    drive(1'b0, 4'h1, 4'h0, 0, 0, 0, 0, 4'hF);
    step(); step();
    reset = 1'b0;
    check_cc("reset", 1'b1, 1'b0, 1'b0);
    check("reset.M_valid", {31'd0, M_valid}, 0);
    check("reset.M_icode", {28'd0, M_icode}, 32'h1);
    check("reset.M_dstE", {28'd0, M_dstE}, 32'hF);
    check("reset.M_vals", M_valE | M_valA | {31'd0, M_cnd}, 0);
`ifdef EXEC_BRANCH_STATS_EN
    check("reset.jxx_total", jxx_total, 0);
    check("reset.jxx_taken", jxx_taken, 0);
`endif

    // subq 5-5=0; le with reset CC (ZF=1) is taken
    drive(1'b1, 4'h6, 4'h1, 5, 5, 0, 32'hAA, 4'h2);
    check("subq.e_cnd_le", {31'd0, e_cnd}, 1);
    step();
    check_cc("subq", 1'b1, 1'b0, 1'b0);
    check("subq.M_icode", {28'd0, M_icode}, 6);
    check("subq.M_dstE", {28'd0, M_dstE}, 2);
    check("subq.M_valA", M_valA, 32'hAA);
    check("subq.M_cnd", {31'd0, M_cnd}, 1);
    drive(1'b1, 4'h7, 4'h3, 0, 0, 0, 0, 4'hF);
    check("je.e_cnd", {31'd0, e_cnd}, 1);
    drive(1'b1, 4'h7, 4'h4, 0, 0, 0, 0, 4'hF);
    check("jne.e_cnd", {31'd0, e_cnd}, 0);

    // addq 1+7FFFFFFF overflows to negative
    drive(1'b1, 4'h6, 4'h0, 32'h7FFF_FFFF, 1, 32'h8000_0000, 0, 4'h1);
    step();
    check_cc("addq", 1'b0, 1'b1, 1'b1);
    drive(1'b1, 4'h7, 4'h1, 0, 0, 0, 0, 4'hF);
    check("le.e_cnd", {31'd0, e_cnd}, 0);
    drive(1'b1, 4'h7, 4'h5, 0, 0, 0, 0, 4'hF);
    check("ge.e_cnd", {31'd0, e_cnd}, 1);
    drive(1'b1, 4'h7, 4'h6, 0, 0, 0, 0, 4'hF);
    check("g.e_cnd", {31'd0, e_cnd}, 1);
    drive(1'b1, 4'h7, 4'h2, 0, 0, 0, 0, 4'hF);
    check("l.e_cnd", {31'd0, e_cnd}, 0);
    drive(1'b1, 4'h7, 4'h9, 0, 0, 0, 0, 4'hF);
    check("ifun9.e_cnd", {31'd0, e_cnd}, 0);

    // subq 80000000-1 overflows to positive
    drive(1'b1, 4'h6, 4'h1, 1, 32'h8000_0000, 32'h7FFF_FFFF, 0, 4'h1);
    step();
    check_cc("subq_of", 1'b0, 1'b0, 1'b1);
    drive(1'b1, 4'h7, 4'h2, 0, 0, 0, 0, 4'hF);
    check("l_after_subof.e_cnd", {31'd0, e_cnd}, 1);

    // andq result 0 clears OF; then not-taken and taken cmov
    drive(1'b1, 4'h6, 4'h2, 32'hF0F0_F0F0, 32'h0F0F_0F0F, 0, 0, 4'h1);
    step();
    check_cc("andq", 1'b1, 1'b0, 1'b0);
    drive(1'b1, 4'h2, 4'h4, 0, 32'h1234, 32'h1234, 32'h1234, 4'h3);
    step();
    check("cmovne.M_dstE", {28'd0, M_dstE}, 32'hF);
    check("cmovne.M_cnd", {31'd0, M_cnd}, 0);
    check("cmovne.M_valA", M_valA, 32'h1234);
    drive(1'b1, 4'h2, 4'h3, 0, 32'h1234, 32'h1234, 32'h1234, 4'h3);
    step();
    check("cmove.M_dstE", {28'd0, M_dstE}, 3);
    check("cmove.M_cnd", {31'd0, M_cnd}, 1);

    // exceptions block CC but M still loads
    m_exc = 1'b1;
    drive(1'b1, 4'h6, 4'h3, 32'hFFFF_0000, 32'h0000_FFFF, 32'hFFFF_FFFF, 0, 4'h4);
    step();
    m_exc = 1'b0;
    check_cc("m_exc", 1'b1, 1'b0, 1'b0);
    check("m_exc.M_valE", M_valE, 32'hFFFF_FFFF);
    w_exc = 1'b1;
    drive(1'b1, 4'h6, 4'h1, 0, 1, 1, 0, 4'h4);
    step();
    w_exc = 1'b0;
    check_cc("w_exc", 1'b1, 1'b0, 1'b0);
    check("w_exc.M_valE", M_valE, 1);

    // stall+bubble: stall wins, CC held
    m_stall = 1'b1; m_bubble = 1'b1;
    drive(1'b1, 4'h6, 4'h0, 1, 2, 3, 32'h55, 4'h5);
    step();
    check_cc("stall", 1'b1, 1'b0, 1'b0);
    check("stall.M_valE", M_valE, 1);
    check("stall.M_dstE", {28'd0, M_dstE}, 4);
    check("stall.M_valid", {31'd0, M_valid}, 1);
    // bubble only: NOP into M, but the OPq still sets CC
    m_stall = 1'b0;
    step();
    m_bubble = 1'b0;
    check("bubble.M_icode", {28'd0, M_icode}, 1);
    check("bubble.M_dstE", {28'd0, M_dstE}, 32'hF);
    check("bubble.M_valid", {31'd0, M_valid}, 0);
    check("bubble.M_valE", M_valE, 0);
    check_cc("bubble", 1'b0, 1'b0, 1'b0);

    // reset mid-stream discards a negative-result OPq
    reset = 1'b1;
    drive(1'b1, 4'h6, 4'h1, 1, 0, 32'hFFFF_FFFF, 0, 4'h6);
    step();
    reset = 1'b0;
    check_cc("midreset", 1'b1, 1'b0, 1'b0);
    check("midreset.M_valid", {31'd0, M_valid}, 0);

    // jXX stream with ZF=1: je taken, jne not, jmp taken, plus stalled/bubbled jXX not counted
    drive(1'b1, 4'h7, 4'h3, 0, 0, 0, 0, 4'hF); step();
    drive(1'b1, 4'h7, 4'h4, 0, 0, 0, 0, 4'hF); step();
    check("jne.M_cnd", {31'd0, M_cnd}, 0);
    m_stall = 1'b1;
    drive(1'b1, 4'h7, 4'h0, 0, 0, 0, 0, 4'hF); step();
    m_stall = 1'b0; m_bubble = 1'b1;
    step();
    m_bubble = 1'b0;
    step();
    check("jmp.M_cnd", {31'd0, M_cnd}, 1);
    drive(1'b0, 4'h1, 4'h0, 0, 0, 0, 0, 4'hF); step();
`ifdef EXEC_BRANCH_STATS_EN
    check("stats.jxx_total", jxx_total, 3);
    check("stats.jxx_taken", jxx_taken, 2);
    reset = 1'b1; step(); reset = 1'b0;
    check("stats_reset.jxx_total", jxx_total, 0);
    check("stats_reset.jxx_taken", jxx_taken, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
